sink: RTL and testbench

- Traffic sink / checker: the receiving end of the packet stream produced by the per-node traffic sources.
- Sits on a NoC output port.
- Accepts flits through a valid/ready handshake and decodes the {src node, dest, ID, sequence counter} packet format.
- Checks destination and per-source sequence continuity, and keeps receive and error statistics for the testbench and on-chip monitors.

---
 rtl/sink_if.sv | 21 ++
 rtl/sink.sv | 81 ++++++++
 tb/tb_sink.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/sink_if.sv
// Flit stream handshake between a NoC output port and its traffic sink.
// Master drives the flit and valid; the sink answers with ready.
interface sink_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] data_in;
  logic             valid_in;
  logic             ready_out;

  modport master (
    output data_in,
    output valid_in,
    input  ready_out
  );

  modport slave (
    input  data_in,
    input  valid_in,
    output ready_out
  );
endinterface

// File: rtl/sink.sv
// Traffic sink: accepts flits, checks dest and per-source sequence,
// and keeps receive / error statistics.
module sink #(
  parameter int WIDTH = 32,
  parameter int N = 16,
  parameter int N_ADDR_WIDTH = $clog2(N),
  parameter logic [N_ADDR_WIDTH-1:0] NODE = N_ADDR_WIDTH'(15),
  parameter int STALL_PERIOD = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  sink_if.slave                   flit,
  output logic [31:0]             rx_count,
  output logic [15:0]             seq_err_count,
  output logic [15:0]             dest_err_count,
  output logic                    err_out,
  output logic [N_ADDR_WIDTH-1:0] last_src,
  output logic [7:0]              last_id
);

  localparam int CW = WIDTH - 2 * N_ADDR_WIDTH - 8;
  localparam int NS = 2 ** N_ADDR_WIDTH;
  localparam int SW = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
  localparam logic [SW-1:0] LAST =
    (STALL_PERIOD > 1) ? SW'(STALL_PERIOD - 1) : '0;

  logic [SW-1:0]           stall_cnt;
  logic [NS-1:0]           seen;
  logic [CW-1:0]           exp_cnt [NS];

  logic [N_ADDR_WIDTH-1:0] src;
  logic [N_ADDR_WIDTH-1:0] dst;
  logic [7:0]              id;
  logic [CW-1:0]           cnt;
  logic                    stall_ok;
  logic                    xfer;
  logic                    dest_err;
  logic                    seq_err;

  assign src = flit.data_in[WIDTH-1 -: N_ADDR_WIDTH];
  assign dst = flit.data_in[WIDTH-1-N_ADDR_WIDTH -: N_ADDR_WIDTH];
  assign id  = flit.data_in[CW+7 -: 8];
  assign cnt = flit.data_in[CW-1:0];

  assign stall_ok = (STALL_PERIOD == 0) || (stall_cnt != LAST);
  assign flit.ready_out = rst && stall_ok;
  assign xfer = flit.valid_in && flit.ready_out;

  // First flit from a source only arms its expected counter.
  assign dest_err = (dst != NODE);
  assign seq_err  = seen[src] && (cnt != exp_cnt[src]);

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt      <= '0;
      seen           <= '0;
      rx_count       <= '0;
      seq_err_count  <= '0;
      dest_err_count <= '0;
      err_out        <= 1'b0;
      last_src       <= '0;
      last_id        <= '0;
    end else begin
      if (STALL_PERIOD > 1)
        stall_cnt <= (stall_cnt == LAST) ? '0 : stall_cnt + 1'b1;
      err_out <= xfer && (dest_err || seq_err);
      if (xfer) begin
        rx_count     <= rx_count + 1'b1;
        seen[src]    <= 1'b1;
        exp_cnt[src] <= cnt + 1'b1;
        last_src     <= src;
        last_id      <= id;
        if (dest_err && dest_err_count != 16'hFFFF)
          dest_err_count <= dest_err_count + 1'b1;
        if (seq_err && seq_err_count != 16'hFFFF)
          seq_err_count <= seq_err_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sink.sv
// Bench for sink: directed scenarios plus random traffic against
// a queue-free per-source reference model.
module tb_sink;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rst_bp = 1'b0;
  always #5 clk = ~clk;

  sink_if #(.WIDTH(32)) bus ();
  sink_if #(.WIDTH(32)) bus_bp ();

  logic [31:0] rx_count, rx_count_bp;
  logic [15:0] seq_cnt, dest_cnt, seq_cnt_bp, dest_cnt_bp;
  logic        err_out, err_out_bp;
  logic [3:0]  last_src, last_src_bp;
  logic [7:0]  last_id, last_id_bp;

  sink #(.STALL_PERIOD(0)) dut (
    .clk(clk), .rst(rst), .flit(bus.slave),
    .rx_count(rx_count), .seq_err_count(seq_cnt),
    .dest_err_count(dest_cnt), .err_out(err_out),
    .last_src(last_src), .last_id(last_id)
  );

  sink #(.STALL_PERIOD(4)) dut_bp (
    .clk(clk), .rst(rst_bp), .flit(bus_bp.slave),
    .rx_count(rx_count_bp), .seq_err_count(seq_cnt_bp),
    .dest_err_count(dest_cnt_bp), .err_out(err_out_bp),
    .last_src(last_src_bp), .last_id(last_id_bp)
  );

  int checks = 0;
  int errors = 0;

  bit          m_seen [16];
  int          m_exp [16];
  int unsigned m_rx;
  int          m_seq, m_dest;
  bit          m_err;
  int          m_src, m_id;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    foreach (m_seen[i]) m_seen[i] = 1'b0;
    m_rx = 0; m_seq = 0; m_dest = 0;
    m_err = 1'b0; m_src = 0; m_id = 0;
  endfunction

  function automatic void model_flit(input logic [31:0] d);
    int s, c;
    bit de, se;
    s  = int'(d[31:28]);
    c  = int'(d[15:0]);
    de = (d[27:24] != 4'd15);
    se = m_seen[s] && (c != m_exp[s]);
    m_seen[s] = 1'b1;
    m_exp[s]  = (c + 1) % 65536;
    m_rx++;
    if (de && m_dest < 65535) m_dest++;
    if (se && m_seq < 65535) m_seq++;
    m_err = de || se;
    m_src = s;
    m_id  = int'(d[23:16]);
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".rx"}, rx_count, m_rx);
    chk({tag, ".seq"}, {16'd0, seq_cnt}, m_seq);
    chk({tag, ".dest"}, {16'd0, dest_cnt}, m_dest);
    chk({tag, ".err"}, {31'd0, err_out}, {31'd0, m_err});
    chk({tag, ".src"}, {28'd0, last_src}, m_src);
    chk({tag, ".id"}, {24'd0, last_id}, m_id);
  endtask

  task automatic step(input string tag, input bit v,
                      input logic [31:0] d);
    @(negedge clk);
    bus.valid_in = v;
    bus.data_in  = d;
    #1;
    chk({tag, ".ready"}, {31'd0, bus.ready_out}, {31'd0, rst});
    @(posedge clk);
    if (!rst) model_reset();
    else if (v) model_flit(d);
    else m_err = 1'b0;
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step("reset", 1'b0, 32'h0);
    rst = 1'b1;
  endtask

  initial begin
    logic [31:0] d;
    int s, c, ready_n;
    bus.valid_in = 1'b0;
    bus.data_in = '0;
    bus_bp.valid_in = 1'b0;
    bus_bp.data_in = '0;
    model_reset();

    do_reset();
    do_reset();

    for (int i = 0; i < 3; i++)
      step("basic", 1'b1, 32'h3F020000 + i);
    chk("basic.rx3", rx_count, 32'd3);
    chk("basic.src3", {28'd0, last_src}, 32'd3);

    do_reset();
    step("gap5", 1'b1, 32'h3F020005);
    step("gap6", 1'b1, 32'h3F020006);
    step("gap8", 1'b1, 32'h3F020008);
    chk("gap.pulse", {31'd0, err_out}, 32'd1);
    step("gap9", 1'b1, 32'h3F020009);
    chk("gap.seq1", {16'd0, seq_cnt}, 32'd1);
    step("gapidle", 1'b0, 32'h0);

    do_reset();
    step("misroute", 1'b1, 32'h3A020000);
    chk("misroute.dest1", {16'd0, dest_cnt}, 32'd1);
    step("misidle", 1'b0, 32'h0);

    do_reset();
    step("wrapff", 1'b1, 32'h1F01FFFF);
    step("wrap00", 1'b1, 32'h1F010000);
    for (int i = 1; i < 5; i++) begin
      step("ilv1", 1'b1, 32'h1F010000 + i);
      step("ilv2", 1'b1, 32'h2F030000 + i - 1);
    end
    chk("ilv.seq0", {16'd0, seq_cnt}, 32'd0);

    for (int i = 0; i < 300; i++) begin
      s = int'($urandom_range(0, 4));
      if (m_seen[s] && $urandom_range(0, 9) != 0) c = m_exp[s];
      else c = int'($urandom_range(0, 65535));
      d[31:28] = 4'(s);
      d[27:24] = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'd15;
      d[23:16] = 8'($urandom);
      d[15:0]  = 16'(c);
      step("rand", ($urandom_range(0, 4) != 0), d);
    end

    do_reset();
    for (int i = 0; i < 5; i++)
      step("mid", 1'b1, 32'h3F020000 + i);
    rst = 1'b0;
    step("midrst", 1'b1, 32'h3F020005);
    chk("midrst.rx0", rx_count, 32'd0);
    rst = 1'b1;
    step("resume", 1'b1, 32'h3F020064);
    chk("resume.rx1", rx_count, 32'd1);
    chk("resume.seq0", {16'd0, seq_cnt}, 32'd0);

    ready_n = 0;
    @(negedge clk);
    #1;
    chk("bp.rstready", {31'd0, bus_bp.ready_out}, 32'd0);
    rst_bp = 1'b1;
    bus_bp.valid_in = 1'b1;
    bus_bp.data_in = 32'h5F070000;
    for (int i = 0; i < 12; i++) begin
      #1;
      chk("bp.ready", {31'd0, bus_bp.ready_out},
          {31'd0, ((i % 4) != 3)});
      if ((i % 4) != 3) ready_n++;
      @(negedge clk);
    end
    bus_bp.valid_in = 1'b0;
    #1;
    chk("bp.rx", rx_count_bp, ready_n);
    chk("bp.rx9", rx_count_bp, 32'd9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
